image_patch_reader: RTL and testbench
=====================================

# image_patch_reader

Reads the 904-bit flattened binary image held by the image buffer and streams it to the first BNN convolution layer as 3x3 pixel patches, one per handshake, row-major. It is the consumer side of the image buffer: it starts once the buffer reports full, walks every kernel position, and signals completion so the controller can clear the buffer for the next character.

## Interface
Parameters:
- IMG_WIDTH, 30, image columns
- IMG_HEIGHT, 30, image rows
- TOTAL_BITS, 904, flattened image width (113 bytes; bits 900..903 unused)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; honoured only in IDLE with img_valid=1
- abort  in  1  synchronous abort to IDLE; no done pulse
- img_valid  in  1  image present (driven from buffer_full)
- img_in  in  904  pixel (r,c) at bit r*30+c; caller holds stable while busy
- patch_valid  out  1  patch_data/row/col/last valid
- patch_ready  in  1  downstream accepts
- patch_data  out  9  bit k*3+j = pixel (row-1+k, col-1+j), k,j in 0..2
- patch_row  out  5  centre-pixel row of current patch
- patch_col  out  5  centre-pixel column of current patch
- patch_last  out  1  final patch of the pass
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse after final handshake

## Operation
- FSM: IDLE -> STREAM on start && img_valid; STREAM -> DONE on handshake with patch_last; DONE -> IDLE unconditionally (done=1 for that one cycle).
- abort in any state -> IDLE next cycle; abort has priority over start and handshake.
- start in STREAM or DONE ignored; start with img_valid=0 ignored.
- Coordinates: row/col counters; col increments per handshake, wraps at last column to first column with row+1.
- Without padding: centre range 1..28, 784 patches, first (1,1), last (28,28).
- All outputs registered; patch data is recomputed from img_in for the next position when a handshake occurs.
- img_in is not latched; changing it during STREAM is a caller error, patch contents then undefined.
- Bits 900..903 of img_in never read.

## Timing
- Reset: patch_valid=0, patch_data=0, patch_row=0, patch_col=0, patch_last=0, busy=0, done=0, FSM=IDLE.
- Latency: start sampled at edge N -> patch_valid=1 with first patch from edge N+1.
- Handshake: transfer when patch_valid && patch_ready at a rising edge; while patch_valid && !patch_ready all patch outputs hold.
- patch_valid never drops inside a pass except on abort.
- Throughput: one patch/cycle with patch_ready held high; no-pad pass = 784 cycles of valid, done at cycle after last transfer.
- After abort: patch_valid, busy, patch_last = 0 on the next cycle; counters reset to first position.
- Back-to-back: start accepted again in the cycle after done (IDLE).

## Configuration
- PATCH_ZERO_PAD_EN defined: centre range 0..29, 900 patches, first (0,0), last (29,29); pixels outside 0..29 read as 0.
- Undefined: valid-only positions as above, 784 patches.

## Structure
- Package bnn_img_pkg: IMG_WIDTH, IMG_HEIGHT, TOTAL_BITS, KERNEL_SIZE=3, coord_t (logic [4:0]), patch_t (logic [8:0]), FSM state enum.
- Sub-module patch_extract: combinational; img_in + centre row/col -> 9-bit patch, applying zero padding under PATCH_ZERO_PAD_EN. Top holds FSM, counters, output registers.

## Test plan
- Reset mid-STREAM (rst_n low at patch 100) -> all outputs 0 immediately, IDLE, next start begins at (1,1).
- Checkerboard img_in (bit r*30+c = (r+c)&1), ready=1, start -> 784 patches, (1,1) data 9'b010101010, done one cycle after (28,28) with patch_last=1.
- Random patch_ready backpressure -> data/row/col stable while stalled, exactly 784 transfers, none duplicated or skipped.
- start with img_valid=0 -> no activity; start again during STREAM -> ignored, count still 784.
- abort at patch 300 -> patch_valid=0 next cycle, no done; subsequent start restarts at (1,1).
- PATCH_ZERO_PAD_EN, all-ones image -> 900 patches; (0,0) data 9'b110110000, (29,29) data 9'b000011011, (15,15) data 9'h1FF.

Source files
------------

// File: rtl/bnn_img_pkg.sv
// Shared definitions for the BNN image front end: image geometry, kernel
// size, coordinate/patch types and the patch reader state encoding.
package bnn_img_pkg;

    localparam int IMG_WIDTH   = 30;
    localparam int IMG_HEIGHT  = 30;
    localparam int TOTAL_BITS  = 904;
    localparam int KERNEL_SIZE = 3;

    typedef logic [4:0] coord_t;
    typedef logic [8:0] patch_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/patch_extract.sv
// Combinational 3x3 window extraction from the flattened image.
// Output bit k*3+j holds pixel (row-1+k, col-1+j). Any pixel that falls
// outside the image reads as 0; that case is only reachable when the reader
// walks the border positions (PATCH_ZERO_PAD_EN builds).
module patch_extract #(
    parameter int IMG_WIDTH  = 30,
    parameter int IMG_HEIGHT = 30,
    parameter int TOTAL_BITS = 904
) (
    input  logic [TOTAL_BITS-1:0] i_img,
    input  logic [4:0]            i_row,
    input  logic [4:0]            i_col,
    output logic [8:0]            o_patch
);
    import bnn_img_pkg::*;

    localparam int IDX_W = $clog2(TOTAL_BITS);

    // Fetch one pixel, returning 0 for coordinates outside the image.
    function automatic logic pixel_at(input logic [TOTAL_BITS-1:0] img,
                                      input int r,
                                      input int c);
        logic [IDX_W-1:0] idx;
        logic             bit_v;
        if ((r < 0) || (r >= IMG_HEIGHT) || (c < 0) || (c >= IMG_WIDTH)) begin
            idx   = '0;
            bit_v = 1'b0;
        end else begin
            idx   = IDX_W'(r * IMG_WIDTH + c);
            bit_v = img[idx];
        end
        return bit_v;
    endfunction

    for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_krow
        for (genvar j = 0; j < KERNEL_SIZE; j++) begin : g_kcol
            assign o_patch[k*KERNEL_SIZE + j] =
                pixel_at(i_img, int'(i_row) + k - 32'sd1, int'(i_col) + j - 32'sd1);
        end
    end

endmodule

// File: rtl/image_patch_reader.sv
// Streams the buffered binary image to the first conv layer as 3x3 patches,
// one per valid/ready handshake, in row-major order of the centre pixel.
// Build option: PATCH_ZERO_PAD_EN widens the centre range to the full image
// (border pixels outside the image read as 0); otherwise only positions whose
// whole window lies inside the image are produced.
module image_patch_reader #(
    parameter int IMG_WIDTH  = 30,
    parameter int IMG_HEIGHT = 30,
    parameter int TOTAL_BITS = 904
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  img_valid,
    input  logic [TOTAL_BITS-1:0] img_in,
    output logic                  patch_valid,
    input  logic                  patch_ready,
    output logic [8:0]            patch_data,
    output logic [4:0]            patch_row,
    output logic [4:0]            patch_col,
    output logic                  patch_last,
    output logic                  busy,
    output logic                  done
);
    import bnn_img_pkg::*;

`ifdef PATCH_ZERO_PAD_EN
    localparam int FIRST_POS = 0;
    localparam int LAST_ROW  = IMG_HEIGHT - 1;
    localparam int LAST_COL  = IMG_WIDTH - 1;
`else
    localparam int FIRST_POS = 1;
    localparam int LAST_ROW  = IMG_HEIGHT - 2;
    localparam int LAST_COL  = IMG_WIDTH - 2;
`endif

    localparam coord_t C_FIRST    = coord_t'(FIRST_POS);
    localparam coord_t C_LAST_ROW = coord_t'(LAST_ROW);
    localparam coord_t C_LAST_COL = coord_t'(LAST_COL);

    state_t r_state;
    state_t w_state_nxt;

    logic   r_patch_valid;
    patch_t r_patch_data;
    coord_t r_patch_row;
    coord_t r_patch_col;
    logic   r_patch_last;
    logic   r_busy;
    logic   r_done;

    logic   w_hs;
    logic   w_load_first;
    logic   w_advance;
    logic   w_finish;
    logic   w_busy_nxt;
    logic   w_done_nxt;
    coord_t w_next_row;
    coord_t w_next_col;
    coord_t w_ext_row;
    coord_t w_ext_col;
    logic   w_ext_is_last;
    patch_t w_patch;

    assign w_hs = r_patch_valid & patch_ready;

    // Raster step from the patch currently presented to the following one.
    always_comb begin
        w_next_row = r_patch_row;
        w_next_col = r_patch_col;
        if (r_patch_col == C_LAST_COL) begin
            w_next_col = C_FIRST;
            w_next_row = r_patch_row + 5'd1;
        end else begin
            w_next_col = r_patch_col + 5'd1;
            w_next_row = r_patch_row;
        end
    end

    // Window position fed to the extractor: first position while waiting to
    // start, otherwise the position that follows the current patch.
    always_comb begin
        w_ext_row = C_FIRST;
        w_ext_col = C_FIRST;
        if (r_state == ST_STREAM) begin
            w_ext_row = w_next_row;
            w_ext_col = w_next_col;
        end else begin
            w_ext_row = C_FIRST;
            w_ext_col = C_FIRST;
        end
        w_ext_is_last = (w_ext_row == C_LAST_ROW) && (w_ext_col == C_LAST_COL);
    end

    patch_extract #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_extract (
        .i_img   (img_in),
        .i_row   (w_ext_row),
        .i_col   (w_ext_col),
        .o_patch (w_patch)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; abort overrides every other condition.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && img_valid) begin
                        w_state_nxt = ST_STREAM;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (w_hs && r_patch_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: datapath load strobes and next values of the status flags.
    always_comb begin
        w_load_first = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_first = start & img_valid & ~abort;
            end
            ST_STREAM: begin
                w_advance = w_hs & ~r_patch_last & ~abort;
                w_finish  = w_hs &  r_patch_last & ~abort;
            end
            ST_DONE: begin
                w_load_first = 1'b0;
            end
            default: begin
                w_load_first = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_STREAM);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // Registered busy/done status; done is high exactly for the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Patch output registers: load on start or accepted handshake, hold while
    // stalled, clear on abort or after the final patch is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_patch_valid <= 1'b0;
            r_patch_data  <= 9'd0;
            r_patch_row   <= 5'd0;
            r_patch_col   <= 5'd0;
            r_patch_last  <= 1'b0;
        end else if (abort || w_finish) begin
            r_patch_valid <= 1'b0;
            r_patch_data  <= 9'd0;
            r_patch_row   <= 5'd0;
            r_patch_col   <= 5'd0;
            r_patch_last  <= 1'b0;
        end else if (w_load_first || w_advance) begin
            r_patch_valid <= 1'b1;
            r_patch_data  <= w_patch;
            r_patch_row   <= w_ext_row;
            r_patch_col   <= w_ext_col;
            r_patch_last  <= w_ext_is_last;
        end else begin
            r_patch_valid <= r_patch_valid;
            r_patch_data  <= r_patch_data;
            r_patch_row   <= r_patch_row;
            r_patch_col   <= r_patch_col;
            r_patch_last  <= r_patch_last;
        end
    end

    assign patch_valid = r_patch_valid;
    assign patch_data  = r_patch_data;
    assign patch_row   = r_patch_row;
    assign patch_col   = r_patch_col;
    assign patch_last  = r_patch_last;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_image_patch_reader.sv
// Self-checking bench for image_patch_reader. A pass-level model (patch index
// -> centre coordinate -> window bits read straight from the image array)
// is compared against the DUT on every falling edge; directed passes add
// literal expectations for known images.
module tb_image_patch_reader;

    localparam int W = 30;
    localparam int H = 30;
`ifdef PATCH_ZERO_PAD_EN
    localparam int FIRST = 0;
    localparam int LAST  = 29;
`else
    localparam int FIRST = 1;
    localparam int LAST  = 28;
`endif
    localparam int SPAN   = LAST - FIRST + 1;
    localparam int NPATCH = SPAN * SPAN;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         img_valid;
    logic [903:0] img;
    logic         patch_valid;
    logic         patch_ready;
    logic [8:0]   patch_data;
    logic [4:0]   patch_row;
    logic [4:0]   patch_col;
    logic         patch_last;
    logic         busy;
    logic         done;

    image_patch_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .img_valid   (img_valid),
        .img_in      (img),
        .patch_valid (patch_valid),
        .patch_ready (patch_ready),
        .patch_data  (patch_data),
        .patch_row   (patch_row),
        .patch_col   (patch_col),
        .patch_last  (patch_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected window straight from the image: bit k*3+j = pixel(row-1+k, col-1+j).
    function automatic logic [8:0] exp_patch(input int row, input int col);
        logic [8:0] p;
        int r;
        int c;
        p = 9'd0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                r = row - 1 + k;
                c = col - 1 + j;
                if (r >= 0 && r < H && c >= 0 && c < W) p[k*3+j] = img[r*W + c];
            end
        end
        return p;
    endfunction

    task automatic set_checker();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r*W + c] = 1'((r + c) & 1);
        img[903:900] = 4'hF;
    endtask

    task automatic set_random();
        for (int i = 0; i < 904; i++) img[i] = 1'($urandom_range(0, 1));
    endtask

    // ---------------- model + compare process ----------------
    bit         m_in_pass = 1'b0;
    bit         m_done    = 1'b0;
    int         m_idx     = 0;
    int         er;
    int         ec;
    int         xfer_total  = 0;
    int         done_total  = 0;
    int         valid_total = 0;
    logic [8:0] cap_first;
    logic [8:0] cap_last;
    logic [8:0] cap_mid;
    int         cap_last_row;
    int         cap_last_col;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in_pass = 1'b0;
            m_idx     = 0;
            m_done    = 1'b0;
        end
        check("valid", patch_valid, m_in_pass);
        check("busy", busy, m_in_pass);
        check("done", done, m_done);
        if (m_in_pass) begin
            er = FIRST + m_idx / SPAN;
            ec = FIRST + m_idx % SPAN;
            check("row", patch_row, er);
            check("col", patch_col, ec);
            check("data", patch_data, exp_patch(er, ec));
            check("last", patch_last, (m_idx == NPATCH - 1));
        end else begin
            check("last_idle", patch_last, 1'b0);
        end

        if (patch_valid) valid_total++;
        if (patch_valid && patch_ready) xfer_total++;
        if (done) done_total++;
        if (patch_valid && patch_row == 5'(FIRST) && patch_col == 5'(FIRST)) cap_first = patch_data;
        if (patch_valid && patch_row == 5'd15 && patch_col == 5'd15) cap_mid = patch_data;
        if (patch_valid && patch_last) begin
            cap_last     = patch_data;
            cap_last_row = int'(patch_row);
            cap_last_col = int'(patch_col);
        end

        if (!rst_n) begin
            m_in_pass = 1'b0;
        end else if (abort) begin
            m_in_pass = 1'b0;
            m_idx     = 0;
            m_done    = 1'b0;
        end else if (m_in_pass) begin
            m_done = 1'b0;
            if (patch_ready) begin
                if (m_idx == NPATCH - 1) begin
                    m_in_pass = 1'b0;
                    m_done    = 1'b1;
                    m_idx     = 0;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            if (start && img_valid && !m_done) begin
                m_in_pass = 1'b1;
                m_idx     = 0;
            end
            m_done = 1'b0;
        end
    end

    // ---------------- ready driver ----------------
    bit bp_mode = 1'b0;
    initial begin
        patch_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 patch_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n;
        n = 0;
        while (xfer_total < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (xfer_total < target) check("wait_xfers_timeout", xfer_total, target);
    endtask

    // Returns just after the edge that leaves the DONE cycle.
    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_total;
        n  = 0;
        while (done_total == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_total == d0) check("wait_done_timeout", done_total, d0 + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    int x0;
    int v0;
    int d0;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; img_valid = 1'b0; img = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_valid", patch_valid, 1'b0);
        check("rst_data", patch_data, 9'd0);
        check("rst_row", patch_row, 5'd0);
        check("rst_col", patch_col, 5'd0);
        check("rst_last", patch_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        // Start with no image present is ignored.
        set_checker();
        check("model_pin_11", exp_patch(1, 1), 9'b010101010);
        check("model_pin_00", exp_patch(0, 0), 9'b010100000);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        check("noimg_xfers", xfer_total, 0);
        check("noimg_valid", patch_valid, 1'b0);

        // Pass 1: checkerboard, ready held high, stray start mid-pass.
        img_valid = 1'b1;
        x0 = xfer_total; v0 = valid_total; d0 = done_total;
        pulse_start();
        wait_xfers(x0 + 50, 200);
        pulse_start();
        wait_done(NPATCH + 100);
        check("p1_xfers", xfer_total - x0, NPATCH);
        check("p1_valid_cycles", valid_total - v0, NPATCH);
        check("p1_done_count", done_total - d0, 1);
        check("p1_last_row", cap_last_row, LAST);
        check("p1_last_col", cap_last_col, LAST);
`ifdef PATCH_ZERO_PAD_EN
        check("p1_first_data", cap_first, 9'b010100000);
        check("p1_last_data", cap_last, 9'b000001010);
`else
        check("p1_first_data", cap_first, 9'b010101010);
        check("p1_last_data", cap_last, 9'b010101010);
`endif

        // Pass 2: back-to-back start, random image, random backpressure.
        set_random();
        bp_mode = 1'b1;
        x0 = xfer_total; d0 = done_total;
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_valid", patch_valid, 1'b1);
        check("b2b_row", patch_row, 5'(FIRST));
        check("b2b_col", patch_col, 5'(FIRST));
        wait_done(NPATCH * 6 + 100);
        check("p2_xfers", xfer_total - x0, NPATCH);
        check("p2_done_count", done_total - d0, 1);
        bp_mode = 1'b0;

        // Pass 3: abort at patch 300, then restart and complete.
        set_checker();
        x0 = xfer_total; d0 = done_total;
        pulse_start();
        wait_xfers(x0 + 300, 600);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_valid", patch_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_last", patch_last, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", done_total - d0, 0);
        x0 = xfer_total;
        pulse_start();
        check("abort_restart_row", patch_row, 5'(FIRST));
        check("abort_restart_col", patch_col, 5'(FIRST));
        wait_done(NPATCH + 100);
        check("p3_xfers", xfer_total - x0, NPATCH);

        // Pass 4: asynchronous reset at patch 100, then a full pass.
        x0 = xfer_total;
        pulse_start();
        wait_xfers(x0 + 100, 300);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_valid", patch_valid, 1'b0);
        check("mrst_data", patch_data, 9'd0);
        check("mrst_row", patch_row, 5'd0);
        check("mrst_col", patch_col, 5'd0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        x0 = xfer_total;
        pulse_start();
        check("mrst_restart_row", patch_row, 5'(FIRST));
        check("mrst_restart_col", patch_col, 5'(FIRST));
        wait_done(NPATCH + 100);
        check("p4_xfers", xfer_total - x0, NPATCH);

        // Pass 5: all-ones image.
        img = '1;
        x0 = xfer_total;
        pulse_start();
        wait_done(NPATCH + 100);
        check("p5_xfers", xfer_total - x0, NPATCH);
        check("p5_mid_data", cap_mid, 9'h1FF);
`ifdef PATCH_ZERO_PAD_EN
        check("p5_first_data", cap_first, 9'b110110000);
        check("p5_last_data", cap_last, 9'b000011011);
`else
        check("p5_first_data", cap_first, 9'h1FF);
        check("p5_last_data", cap_last, 9'h1FF);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
